// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product handshake bundle for seq_shift_add_multiplier.
// master = operand producer / product consumer, slave = multiplier.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock, WIDTH x WIDTH -> 2*WIDTH.
// Define SIGNED_MULT_EN for two's-complement operands/product; default build is unsigned.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | accumulating one multiplier bit per edge, LSB first
// DONE  | product held with out_valid until out_ready
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_product;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_sum;
    logic [PW-1:0]      w_result;
    logic               w_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = CALC;
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_addend = r_b[r_cnt] ? (PW'(r_a) << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;

`ifdef SIGNED_MULT_EN
    // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
    logic r_neg;

    assign w_a_mag  = bus.a[WIDTH-1] ? ((~bus.a) + WIDTH'(1)) : bus.a;
    assign w_b_mag  = bus.b[WIDTH-1] ? ((~bus.b) + WIDTH'(1)) : bus.b;
    assign w_result = r_neg ? ((~w_sum) + PW'(1)) : w_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_neg <= 1'b0;
        else if (w_accept) r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
`else
    assign w_a_mag  = bus.a;
    assign w_b_mag  = bus.b;
    assign w_result = w_sum;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_a_mag;
                r_b   <= w_b_mag;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == CALC) begin
                r_acc <= w_sum;
                if (r_cnt == LAST) begin
                    r_cnt     <= '0;
                    r_product <= w_result;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_product;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Randomized self-checking bench for seq_shift_add_multiplier against an arithmetic reference.
module tb_seq_shift_add_multiplier;
    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;
    localparam int BOUND = 4 * WIDTH + 20;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
        longint pa;
        longint pb;
`ifdef SIGNED_MULT_EN
        pa = longint'($signed(ma));
        pb = longint'($signed(mb));
`else
        pa = longint'(ma);
        pb = longint'(mb);
`endif
        return PW'(pa * pb);
    endfunction

    // Present operands, wait for acceptance, then return the product once out_valid rises.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          output logic [PW-1:0] p, output int lat, output bit ok);
        int g;
        g   = 0;
        lat = 0;
        ok  = 1'b0;
        p   = '0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        while (!bus.in_ready && g < BOUND) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= BOUND; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        p = bus.product;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== '0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_corners();
        logic [WIDTH-1:0] va [4];
        logic [WIDTH-1:0] vb [4];
        logic [PW-1:0]    p;
        int               lat;
        bit               ok;
        va = '{'1, '0, WIDTH'(1), WIDTH'(1) << (WIDTH - 1)};
        vb = '{'1, WIDTH'(9), WIDTH'(1), WIDTH'(1) << (WIDTH - 1)};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], p, lat, ok);
            n_cmp++;
            if (!ok || lat != WIDTH || p !== model(va[i], vb[i])) begin
                n_err++;
                $display("FAIL corner[%0d] a=%h b=%h: product=%h latency=%0d, required %h latency=%0d",
                         i, va[i], vb[i], p, lat, model(va[i], vb[i]), WIDTH);
            end
`ifndef SIGNED_MULT_EN
            if (i == 0) begin
                n_cmp++;
                if (p !== PW'(((1 << WIDTH) - 1) * ((1 << WIDTH) - 1))) begin
                    n_err++;
                    $display("FAIL max_unsigned: product=%h required %h", p,
                             PW'(((1 << WIDTH) - 1) * ((1 << WIDTH) - 1)));
                end
            end
`endif
            // Transfer happens on the next edge; in_ready must then be back.
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL corner_release[%0d]: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                         i, bus.in_ready, bus.out_valid, bus.busy);
            end
        end
    endtask

`ifdef SIGNED_MULT_EN
    task automatic test_signed();
        logic [PW-1:0] p;
        int            lat;
        bit            ok;
        logic [3:0]    sa [3];
        logic [3:0]    sb [3];
        logic [7:0]    se [3];
        sa = '{4'h8, 4'hF, 4'h5};
        sb = '{4'h8, 4'h7, 4'hD};
        se = '{8'h40, 8'hF9, 8'hF1};
        bus.out_ready = 1'b1;
        if (WIDTH == 4) begin
            for (int i = 0; i < 3; i++) begin
                run_op(WIDTH'(sa[i]), WIDTH'(sb[i]), p, lat, ok);
                n_cmp++;
                if (!ok || p !== PW'(se[i])) begin
                    n_err++;
                    $display("FAIL signed[%0d]: product=%h required %h", i, p, se[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [PW-1:0]    p;
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tv;
        int               lat;
        bit               ok;
        ta = WIDTH'(6);
        tv = WIDTH'(7);
        bus.out_ready = 1'b0;
        run_op(ta, tv, p, lat, ok);
        n_cmp++;
        if (!ok || p !== model(ta, tv)) begin
            n_err++;
            $display("FAIL bp_product: product=%h required %h", p, model(ta, tv));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.product !== model(ta, tv) || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: out_valid=%b product=%h in_ready=%b busy=%b, required 1 %h 0 1",
                         i, bus.out_valid, bus.product, bus.in_ready, bus.busy, model(ta, tv));
            end
        end
        // in_valid with new operands and out_ready together: only the output transfer happens.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = WIDTH'(3);
        bus.b         = WIDTH'(2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.product !== model(ta, tv)) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b product=%h, required 0 1 0 %h",
                     bus.out_valid, bus.in_ready, bus.busy, bus.product, model(ta, tv));
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_late_accept: busy=%b in_ready=%b, required 1 0", bus.busy, bus.in_ready);
        end
        // Operand changes and in_valid during CALC must not disturb the result.
        for (int i = 0; i < WIDTH - 1; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.product !== model(WIDTH'(3), WIDTH'(2))) begin
            n_err++;
            $display("FAIL calc_ignore: out_valid=%b product=%h, required 1 %h",
                     bus.out_valid, bus.product, model(WIDTH'(3), WIDTH'(2)));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        logic [PW-1:0] p;
        int            lat;
        bit            ok;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = '1;
        bus.b        = '1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.product !== '0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset: out_valid=%b product=%h in_ready=%b busy=%b, required 0 0 1 0",
                     bus.out_valid, bus.product, bus.in_ready, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(WIDTH'(3), WIDTH'(5), p, lat, ok);
        n_cmp++;
        if (!ok || lat != WIDTH || p !== model(WIDTH'(3), WIDTH'(5))) begin
            n_err++;
            $display("FAIL after_reset_op: product=%h latency=%0d, required %h latency=%0d",
                     p, lat, model(WIDTH'(3), WIDTH'(5)), WIDTH);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [PW-1:0]    p;
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tv;
        int               lat;
        int               hold;
        bit               ok;
        for (int n = 0; n < 30; n++) begin
            ta            = WIDTH'($urandom);
            tv            = WIDTH'($urandom);
            hold          = $urandom_range(0, 3);
            bus.out_ready = (hold == 0);
            run_op(ta, tv, p, lat, ok);
            n_cmp++;
            if (!ok || lat != WIDTH || p !== model(ta, tv)) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h: product=%h latency=%0d, required %h latency=%0d",
                         n, ta, tv, p, lat, model(ta, tv), WIDTH);
            end
            if (hold != 0) begin
                repeat (hold) @(posedge clk);
                #1;
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.product !== model(ta, tv)) begin
                    n_err++;
                    $display("FAIL random_hold[%0d]: out_valid=%b product=%h, required 1 %h",
                             n, bus.out_valid, bus.product, model(ta, tv));
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.product !== model(ta, tv)) begin
                n_err++;
                $display("FAIL random_release[%0d]: out_valid=%b product=%h, required 0 %h",
                         n, bus.out_valid, bus.product, model(ta, tv));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_q[$];
        int            acc_cyc[$];
        int            n_out;
        logic [PW-1:0] e;
        n_out         = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 8 * (WIDTH + 2); cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n_cmp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (bus.product !== e) begin
                    n_err++;
                    $display("FAIL b2b_product[%0d]: product=%h required %h", n_out, bus.product, e);
                end
                n_out++;
            end
            if (bus.in_ready) begin
                bus.a = WIDTH'($urandom);
                bus.b = WIDTH'($urandom);
                exp_q.push_back(model(bus.a, bus.b));
                acc_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (n_out < 6) begin
            n_err++;
            $display("FAIL b2b_count: outputs=%0d required at least 6", n_out);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] != WIDTH + 2) begin
                n_err++;
                $display("FAIL b2b_interval[%0d]: interval=%0d required %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], WIDTH + 2);
            end
        end
        repeat (BOUND) @(posedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_corners();
`ifdef SIGNED_MULT_EN
        test_signed();
`endif
        test_backpressure();
        test_reset_midop();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
